// File: rtl/ctl_duck_pkg.sv
// Shared definitions for the multi-channel duck flight controller:
// channel state encoding and default screen geometry / timing values.
package ctl_duck_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FLYING    = 3'd1,
    ST_HIT_PAUSE = 3'd2,
    ST_FALLING   = 3'd3,
    ST_ESCAPE    = 3'd4,
    ST_DONE      = 3'd5
  } duck_state_e;

  localparam int X_MAX_DEF      = 960;
  localparam int Y_GROUND_DEF   = 600;
  localparam int Y_TOP_DEF      = 0;
  localparam int DEF_V_SPD_DEF  = 15;
  localparam int FLY_FRAMES_DEF = 600;
  localparam int HIT_FRAMES_DEF = 30;
  localparam int FALL_SPD_DEF   = 8;
  localparam int ESC_SPD_DEF    = 8;

endpackage

// File: rtl/duck_mover.sv
// One duck channel: flight FSM, bouncing position datapath and frame timer.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for launch; position holds its last value
// FLYING     | bouncing inside the screen bounds, flight timer running
// HIT_PAUSE  | shot; position frozen for HIT_FRAMES frames
// FALLING    | dropping at FALL_SPD until the ground
// ESCAPE     | flight timed out; rising at ESC_SPD until the top
// DONE       | single cycle; completion pulse and result
//
// The frame timer is a down-counter loaded on entry to FLYING/HIT_PAUSE;
// the frame that sees it at 1 is the last frame of that phase.
module duck_mover
  import ctl_duck_pkg::*;
#(
  parameter int POS_W      = 11,
  parameter int SPD_W      = 5,
  parameter int CNT_W      = 10,
  parameter int X_MAX      = X_MAX_DEF,
  parameter int Y_GROUND   = Y_GROUND_DEF,
  parameter int Y_TOP      = Y_TOP_DEF,
  parameter int DEF_V_SPD  = DEF_V_SPD_DEF,
  parameter int FLY_FRAMES = FLY_FRAMES_DEF,
  parameter int HIT_FRAMES = HIT_FRAMES_DEF,
  parameter int FALL_SPD   = FALL_SPD_DEF,
  parameter int ESC_SPD    = ESC_SPD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             new_frame,
  input  logic             launch,
  input  logic             launch_dir,
  input  logic [POS_W-1:0] start_x,
  input  logic [SPD_W-1:0] h_spd,
  input  logic [SPD_W-1:0] v_spd,
  input  logic             hit_in,
  output logic [POS_W-1:0] x,
  output logic [POS_W-1:0] y,
  output logic             show,
  output logic             hit,
  output logic             done,
  output logic             result,
  output logic             busy_nxt
);

  localparam logic [POS_W:0]   XMAX_E  = X_MAX[POS_W:0];
  localparam logic [POS_W:0]   YGND_E  = Y_GROUND[POS_W:0];
  localparam logic [POS_W:0]   YTOP_E  = Y_TOP[POS_W:0];
  localparam logic [POS_W:0]   FALL_E  = FALL_SPD[POS_W:0];
  localparam logic [POS_W:0]   ESC_E   = ESC_SPD[POS_W:0];
  localparam logic [SPD_W-1:0] DEFV    = DEF_V_SPD[SPD_W-1:0];
  localparam logic [CNT_W-1:0] FLY_LD  = FLY_FRAMES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] HIT_LD  = HIT_FRAMES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  duck_state_e      state_q, state_d;
  logic [POS_W-1:0] x_d, y_d;
  logic             right_q, right_d;
  logic             up_q, up_d;
  logic [SPD_W-1:0] h_q, h_d, v_q, v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [POS_W-1:0] h_w, v_w;
  logic [POS_W:0]   x_inc, y_inc, y_fall;
  logic [POS_W-1:0] x_dec, y_dec, y_esc;

  assign h_w    = {{(POS_W-SPD_W){1'b0}}, h_q};
  assign v_w    = {{(POS_W-SPD_W){1'b0}}, v_q};
  assign x_inc  = {1'b0, x} + {1'b0, h_w};
  assign y_inc  = {1'b0, y} + {1'b0, v_w};
  assign y_fall = {1'b0, y} + FALL_E;
  assign x_dec  = x - h_w;
  assign y_dec  = y - v_w;
  assign y_esc  = y - ESC_E[POS_W-1:0];

  assign busy_nxt = (state_d != ST_IDLE);

  // Next-state, position and timer update for this channel.
  always_comb begin
    state_d = state_q;
    x_d     = x;
    y_d     = y;
    right_d = right_q;
    up_d    = up_q;
    h_d     = h_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_FLYING;
          x_d     = ({1'b0, start_x} >= XMAX_E) ? XMAX_E[POS_W-1:0] : start_x;
          y_d     = YGND_E[POS_W-1:0];
          right_d = launch_dir;
          up_d    = 1'b1;
          h_d     = h_spd;
          v_d     = (v_spd == '0) ? DEFV : v_spd;
          cnt_d   = FLY_LD;
        end
      end
      ST_FLYING: begin
        // A hit outranks both movement and the timeout on the same cycle.
        if (hit_in) begin
          state_d = ST_HIT_PAUSE;
          cnt_d   = HIT_LD;
        end else if (new_frame) begin
          if (right_q) begin
            if (x_inc >= XMAX_E) begin
              x_d     = XMAX_E[POS_W-1:0];
              right_d = 1'b0;
            end else begin
              x_d = x_inc[POS_W-1:0];
            end
          end else begin
            if ({1'b0, x} <= {1'b0, h_w}) begin
              x_d     = '0;
              right_d = 1'b1;
            end else begin
              x_d = x_dec;
            end
          end
          if (up_q) begin
            if ({1'b0, y} <= YTOP_E + {1'b0, v_w}) begin
              y_d  = YTOP_E[POS_W-1:0];
              up_d = 1'b0;
            end else begin
              y_d = y_dec;
            end
          end else begin
            if (y_inc >= YGND_E) begin
              y_d  = YGND_E[POS_W-1:0];
              up_d = 1'b1;
            end else begin
              y_d = y_inc[POS_W-1:0];
            end
          end
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = ST_ESCAPE;
        end
      end
      ST_HIT_PAUSE: begin
        if (new_frame) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = ST_FALLING;
        end
      end
      ST_FALLING: begin
        if (new_frame) begin
          if (y_fall >= YGND_E) begin
            y_d     = YGND_E[POS_W-1:0];
            state_d = ST_DONE;
          end else begin
            y_d = y_fall[POS_W-1:0];
          end
        end
      end
      ST_ESCAPE: begin
        if (new_frame) begin
          if ({1'b0, y} <= YTOP_E + ESC_E) begin
            y_d     = YTOP_E[POS_W-1:0];
            state_d = ST_DONE;
          end else begin
            y_d = y_esc;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Channel state, position and latched launch parameters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      x       <= '0;
      y       <= '0;
      right_q <= 1'b0;
      up_q    <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x       <= x_d;
      y       <= y_d;
      right_q <= right_d;
      up_q    <= up_d;
      h_q     <= h_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sprite flags decoded from the next state so they line up with position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      show   <= 1'b0;
      hit    <= 1'b0;
      done   <= 1'b0;
      result <= 1'b0;
    end else begin
      show   <= (state_d == ST_FLYING) || (state_d == ST_HIT_PAUSE) ||
                (state_d == ST_FALLING) || (state_d == ST_ESCAPE);
      hit    <= (state_d == ST_HIT_PAUSE) || (state_d == ST_FALLING);
      done   <= (state_d == ST_DONE);
      result <= (state_d == ST_DONE) && (state_q == ST_FALLING);
    end
  end

endmodule

// File: rtl/ctl_duck_multi.sv
// Multi-channel duck position controller: N_DUCKS independent duck_mover
// channels plus a registered count of busy channels.
module ctl_duck_multi
  import ctl_duck_pkg::*;
#(
  parameter int N_DUCKS    = 2,
  parameter int POS_W      = 11,
  parameter int SPD_W      = 5,
  parameter int X_MAX      = X_MAX_DEF,
  parameter int Y_GROUND   = Y_GROUND_DEF,
  parameter int Y_TOP      = Y_TOP_DEF,
  parameter int DEF_V_SPD  = DEF_V_SPD_DEF,
  parameter int FLY_FRAMES = FLY_FRAMES_DEF,
  parameter int HIT_FRAMES = HIT_FRAMES_DEF,
  parameter int FALL_SPD   = FALL_SPD_DEF,
  parameter int ESC_SPD    = ESC_SPD_DEF,
  parameter int CNT_W      = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           new_frame,
  input  logic [N_DUCKS-1:0]             launch,
  input  logic [N_DUCKS-1:0]             launch_dir,
  input  logic [N_DUCKS*POS_W-1:0]       start_x,
  input  logic [N_DUCKS*SPD_W-1:0]       h_spd,
  input  logic [N_DUCKS*SPD_W-1:0]       v_spd,
  input  logic [N_DUCKS-1:0]             hit_in,
  output logic [N_DUCKS*POS_W-1:0]       duck_x,
  output logic [N_DUCKS*POS_W-1:0]       duck_y,
  output logic [N_DUCKS-1:0]             duck_show,
  output logic [N_DUCKS-1:0]             duck_hit,
  output logic [N_DUCKS-1:0]             duck_done,
  output logic [N_DUCKS-1:0]             duck_result,
  output logic [$clog2(N_DUCKS+1)-1:0]   active_cnt
);

  localparam int ACW = $clog2(N_DUCKS + 1);

  logic [N_DUCKS-1:0] busy_nxt;
  logic [ACW-1:0]     active_d;

  for (genvar g = 0; g < N_DUCKS; g++) begin : g_ch
    duck_mover #(
      .POS_W     (POS_W),
      .SPD_W     (SPD_W),
      .CNT_W     (CNT_W),
      .X_MAX     (X_MAX),
      .Y_GROUND  (Y_GROUND),
      .Y_TOP     (Y_TOP),
      .DEF_V_SPD (DEF_V_SPD),
      .FLY_FRAMES(FLY_FRAMES),
      .HIT_FRAMES(HIT_FRAMES),
      .FALL_SPD  (FALL_SPD),
      .ESC_SPD   (ESC_SPD)
    ) u_mover (
      .clk       (clk),
      .rst       (rst),
      .new_frame (new_frame),
      .launch    (launch[g]),
      .launch_dir(launch_dir[g]),
      .start_x   (start_x[g*POS_W +: POS_W]),
      .h_spd     (h_spd[g*SPD_W +: SPD_W]),
      .v_spd     (v_spd[g*SPD_W +: SPD_W]),
      .hit_in    (hit_in[g]),
      .x         (duck_x[g*POS_W +: POS_W]),
      .y         (duck_y[g*POS_W +: POS_W]),
      .show      (duck_show[g]),
      .hit       (duck_hit[g]),
      .done      (duck_done[g]),
      .result    (duck_result[g]),
      .busy_nxt  (busy_nxt[g])
    );
  end

  // Popcount of channels that will be out of IDLE after this edge.
  always_comb begin
    active_d = '0;
    for (int i = 0; i < N_DUCKS; i++) begin
      active_d = active_d + ACW'(busy_nxt[i]);
    end
  end

  // Register the count so it lines up with the channel outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) active_cnt <= '0;
    else      active_cnt <= active_d;
  end

endmodule

// File: doc/ctl_duck_multi.md
Name: ctl_duck_multi

Overview:
- Multi-channel successor to the single-duck position controller. Runs N_DUCKS independent duck flight engines, each with its own launch, flight, bounce, hit, fall, escape and done sequence.
- Positions advance once per new_frame.
- Sits between the game-round controller (launch/hit/config) and the duck draw stage (x, y, show, hit flag). Screen bounds, speeds and timings are parameters.

Parameters:
N_DUCKS, 2, number of independent duck channels
POS_W, 11, width of x/y position
SPD_W, 5, width of speed inputs
X_MAX, 960, rightmost legal duck x (screen width minus sprite width)
Y_GROUND, 600, spawn/landing y
Y_TOP, 0, topmost legal y
DEF_V_SPD, 15, vertical speed used when the launch v speed is 0
FLY_FRAMES, 600, frames in flight before the duck escapes
HIT_FRAMES, 30, frames frozen after a hit
FALL_SPD, 8, px/frame while falling
ESC_SPD, 8, px/frame while escaping upward
CNT_W, 10, frame counter width (must hold FLY_FRAMES)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
new_frame  in  1  one-cycle pulse per video frame
launch  in  N_DUCKS  per-channel launch request, level sampled each cycle
launch_dir  in  N_DUCKS  1 = start moving right, 0 = left
start_x  in  N_DUCKS*POS_W  packed launch x per channel
h_spd  in  N_DUCKS*SPD_W  packed horizontal speed
v_spd  in  N_DUCKS*SPD_W  packed vertical speed
hit_in  in  N_DUCKS  per-channel shot-hit pulse from the hit detector
duck_x  out  N_DUCKS*POS_W  packed x
duck_y  out  N_DUCKS*POS_W  packed y
duck_show  out  N_DUCKS  sprite visible
duck_hit  out  N_DUCKS  hit sprite select
duck_done  out  N_DUCKS  one-cycle completion pulse
duck_result  out  N_DUCKS  valid with duck_done: 1 = shot, 0 = escaped
active_cnt  out  $clog2(N_DUCKS+1)  number of channels not in IDLE

Behaviour:
- Reset, asynchronous, applied immediately: all channels go to IDLE; x = y = 0; all outputs 0.
- All outputs are registered.
- Per-channel FSM: IDLE -> FLYING -> (HIT_PAUSE -> FALLING | ESCAPE) -> DONE -> IDLE.
- IDLE:
  - launch[i] = 1 latches start_x (clamped to X_MAX), y = Y_GROUND, dir, h_spd, and v_spd (0 is replaced by DEF_V_SPD).
  - Frame counter is cleared; next cycle is FLYING.
  - Speeds are held fixed for the whole flight.
- FLYING:
  - On new_frame: x moves ±h by direction, y moves ±v by direction; frame counter +1.
  - Right bound: if x + h >= X_MAX, then x = X_MAX and direction flips to left.
  - Left bound: if x <= h, then x = 0 and direction flips to right.
  - Top bound: if y <= Y_TOP + v, then y = Y_TOP and vertical direction flips to down.
  - Ground bound: if y + v >= Y_GROUND, then y = Y_GROUND and vertical direction flips to up.
  - Clamp and flip happen in the same update; there is no wrap-around or underflow.
  - Initial vertical direction is up.
  - Corner case: both axes clamp and flip in the same update.
- hit_in[i] in FLYING goes to HIT_PAUSE. hit_in is ignored in every other state.
- Counter reaching FLY_FRAMES goes to ESCAPE. If a hit and the timeout occur in the same cycle, the hit wins.
- HIT_PAUSE: x and y are frozen for HIT_FRAMES new_frames, then FALLING.
- FALLING: y += FALL_SPD per new_frame, clamped to Y_GROUND. On reaching Y_GROUND -> DONE with result 1.
- ESCAPE: y -= ESC_SPD per new_frame, clamped to Y_TOP; x is held. On reaching Y_TOP -> DONE with result 0.
- DONE: lasts one cycle. duck_done is pulsed, duck_result is valid, show = 0, next state is IDLE. A launch in DONE is ignored.
- A launch in any non-IDLE state is ignored.
- duck_show = 1 in FLYING, HIT_PAUSE, FALLING and ESCAPE.
- duck_hit = 1 in HIT_PAUSE and FALLING.
- Latency: launch at cycle t gives show = 1 and position at start_x/Y_GROUND at t+1. new_frame at t gives the updated position at t+1.
- Channels are fully independent; their events may coincide.
- active_cnt is the registered popcount of non-IDLE channels.

Decomposition:
- Package ctl_duck_pkg holds the channel state enum (IDLE, FLYING, HIT_PAUSE, FALLING, ESCAPE, DONE) and the screen-bound and default-speed constants.
- Sub-module duck_mover holds one channel's FSM, position datapath and frame counter.
- ctl_duck_multi generate-instantiates N_DUCKS duck_movers and computes active_cnt.

Test Plan:
- Launch ch0 with start_x=100, dir=right, h=4, v=10; one new_frame -> x=104, y=590, show=1, hit=0; ch1 stays IDLE at 0/0.
- Right/top bounce: x=958, y=5, moving right-up with h=4, v=10 -> next frame x=960, y=0; following frame x=956, y=10.
- Hit at y=300 -> 30 frames frozen with duck_hit=1 -> falls 8/frame and clamps at 600 after 38 frames -> duck_done pulse with result=1, then IDLE.
- No hit -> frame 600 enters ESCAPE -> y decreases to 0 -> done with result=0. hit_in on the same cycle as the timeout -> HIT_PAUSE instead.
- Launch with v_spd=0 -> first frame y=585. A second launch while FLYING is ignored. Both channels launched together -> active_cnt=2.
- rst driven low mid-flight, asynchronous to clk -> all outputs 0 immediately. After release, channels stay IDLE until launch.
